// File: rtl/booth_seq_ctrl_pkg.sv
// Shared definitions for the radix-2 Booth sequencing controller.
// Holds the state encodings, the Booth pair codes and the per-state control decode.
package booth_seq_ctrl_pkg;

  localparam int DEFAULT_N = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_EVAL  = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Pair is {Q_LSQ_0, Q_LSQ_1}: a 1->0 transition means subtract, 0->1 means add.
  localparam logic [1:0] BP_SUB = 2'b10;
  localparam logic [1:0] BP_ADD = 2'b01;

  typedef struct packed {
    logic load_a;
    logic load_b;
    logic load_add;
    logic add_sub;
    logic shift;
    logic busy;
    logic done;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [2:0] st, input logic [1:0] pair);
    ctrl_t c;
    c = '0;
    case (st)
      ST_LOAD: begin
        c.load_a = 1'b1;
        c.load_b = 1'b1;
        c.busy   = 1'b1;
      end
      ST_EVAL: begin
        c.busy = 1'b1;
        if (pair == BP_SUB) begin
          c.load_add = 1'b1;
          c.add_sub  = 1'b1;
        end else if (pair == BP_ADD) begin
          c.load_add = 1'b1;
        end
      end
      ST_SHIFT: begin
        c.shift = 1'b1;
        c.busy  = 1'b1;
      end
      ST_DONE: begin
        c.done = 1'b1;
        c.busy = 1'b1;
      end
      // Illegal encodings drive nothing for the single cycle before recovery.
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/booth_seq_ctrl_iter_cnt.sv
// Iteration down-counter: loads N, decrements once per shift, flags the last iteration.
module booth_seq_ctrl_iter_cnt #(
  parameter int N     = 4,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = CNT_W'(N);
    end else if (dec) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/booth_seq_ctrl.sv
// Radix-2 Booth multiplier sequencer: LOAD, then N EVAL/SHIFT pairs, then a one-cycle DONE.
module booth_seq_ctrl
  import booth_seq_ctrl_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Q_LSQ_0,
  input  logic             Q_LSQ_1,
  output logic             load_A,
  output logic             load_B,
  output logic             load_add,
  output logic             add_sub,
  output logic             shift_HQ_LQ_Q_1,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt
);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       cnt_clr;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_last;
  ctrl_t      ctrl;

  booth_seq_ctrl_iter_cnt #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_iter_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .load (cnt_load),
    .dec  (cnt_dec),
    .cnt  (iter_cnt),
    .last (cnt_last)
  );

  always_comb begin
    state_d  = ST_IDLE;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = start ? ST_LOAD : ST_IDLE;
      ST_LOAD: begin
        cnt_load = 1'b1;
        state_d  = ST_EVAL;
      end
      ST_EVAL:  state_d = ST_SHIFT;
      ST_SHIFT: begin
        cnt_dec = 1'b1;
        state_d = cnt_last ? ST_DONE : ST_EVAL;
      end
      ST_DONE:  state_d = ST_IDLE;
      // Recover from a corrupted state and leave the counter in its idle value.
      default: begin
        cnt_clr = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign ctrl            = decode_ctrl(state_q, {Q_LSQ_0, Q_LSQ_1});
  assign load_A          = ctrl.load_a;
  assign load_B          = ctrl.load_b;
  assign load_add        = ctrl.load_add;
  assign add_sub         = ctrl.add_sub;
  assign shift_HQ_LQ_Q_1 = ctrl.shift;
  assign busy            = ctrl.busy;
  assign done            = ctrl.done;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl: cycle-phase reference model, directed scenarios and a
// closed-loop Booth datapath producing real products.
module tb_booth_seq_ctrl;

  localparam int N    = 4;
  localparam int CW   = $clog2(N + 1);
  localparam int LAST = 2 * N + 2;

  logic          clk = 1'b0;
  logic          rst, start;
  logic          q0_r, q1_r, cl_mode;
  logic          Q_LSQ_0, Q_LSQ_1;
  logic          load_A, load_B, load_add, add_sub, shift_HQ_LQ_Q_1, busy, done;
  logic [CW-1:0] iter_cnt;

  // Datapath model: HQ carries one guard bit so a -2^(N-1) multiplicand cannot overflow.
  logic [N:0]    hq;
  logic [N-1:0]  lq, a_reg, a_in, b_in;
  logic          qm1;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  assign Q_LSQ_0 = cl_mode ? lq[0] : q0_r;
  assign Q_LSQ_1 = cl_mode ? qm1   : q1_r;

  booth_seq_ctrl #(.N(N), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .Q_LSQ_0         (Q_LSQ_0),
    .Q_LSQ_1         (Q_LSQ_1),
    .load_A          (load_A),
    .load_B          (load_B),
    .load_add        (load_add),
    .add_sub         (add_sub),
    .shift_HQ_LQ_Q_1 (shift_HQ_LQ_Q_1),
    .busy            (busy),
    .done            (done),
    .iter_cnt        (iter_cnt)
  );

  always @(posedge clk) begin
    if (load_A) a_reg <= a_in;
    if (load_B) begin
      lq  <= b_in;
      hq  <= '0;
      qm1 <= 1'b0;
    end
    if (load_add) hq <= add_sub ? hq - {a_reg[N-1], a_reg} : hq + {a_reg[N-1], a_reg};
    if (shift_HQ_LQ_Q_1) {hq, lq, qm1} <= {hq[N], hq, lq};
  end

  // Reference: k = cycles since the accepted start (0 = idle), LOAD at 1, DONE at 2N+2.
  int k = 0;
  bit model_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      k        <= 0;
      model_ok <= 1'b1;
    end else if (k == 0) begin
      k <= start ? 1 : 0;
    end else begin
      k <= (k == LAST) ? 0 : k + 1;
    end
  end

  function automatic logic [6+CW:0] expect_out(input int kk, input logic p0, input logic p1);
    logic          ev, sh;
    logic [CW-1:0] cnt;
    ev  = (kk >= 2) && (kk <= 2 * N) && (kk % 2 == 0);
    sh  = (kk >= 3) && (kk <= 2 * N + 1) && (kk % 2 == 1);
    cnt = (kk >= 2 && kk <= 2 * N + 1) ? CW'(N - (kk - 2) / 2) : '0;
    return {kk == 1, kk == 1, ev && (p0 != p1), ev && p0 && !p1, sh, kk != 0, kk == LAST, cnt};
  endfunction

  logic [6+CW:0] got_v, exp_v;
  assign got_v = {load_A, load_B, load_add, add_sub, shift_HQ_LQ_Q_1, busy, done, iter_cnt};

  always @(negedge clk) begin
    if (model_ok) begin
      exp_v = expect_out(k, Q_LSQ_0, Q_LSQ_1);
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL model_cycle k=%0d got=%b required=%b", k, got_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mul_check(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2*N-1:0] exp);
    int seen;
    seen   = -1;
    a_in   = a;
    b_in   = b;
    start  = 1'b1;
    for (int c = 0; c <= LAST + 3; c++) begin
      @(negedge clk);
      if (done && seen < 0) begin
        seen = c;
        chk("product", 32'({hq[N-1:0], lq}), 32'(exp));
      end
      next_cycle();
      start = 1'b0;
    end
    chk("mul_latency", 32'(seen), 32'(LAST));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int dn;
    logic signed [N-1:0] sa, sb;
    int prod;
    rst = 1'b1; start = 1'b1; q0_r = 1'b0; q1_r = 1'b0; cl_mode = 1'b0;
    a_in = '0; b_in = '0;

    // Reset held with start high.
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge clk);
      chk("reset_outputs", 32'(got_v), 32'h0);
    end
    next_cycle();
    rst = 1'b0; start = 1'b0;
    next_cycle();

    // Quiet operand bits: fixed schedule.
    start = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      if (c > 0)
        chk($sformatf("sched_c%0d", c),
            32'({load_A, load_B, load_add, shift_HQ_LQ_Q_1, done}),
            32'({c == 1, c == 1, 1'b0, (c == 3 || c == 5 || c == 7 || c == 9), c == 10}));
      next_cycle();
      start = 1'b0;
    end

    // Forced pairs in the first three EVAL cycles.
    start = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      case (c)
        2:       {q0_r, q1_r} = 2'b10;
        4:       {q0_r, q1_r} = 2'b01;
        6:       {q0_r, q1_r} = 2'b11;
        default: {q0_r, q1_r} = 2'($urandom);
      endcase
      @(negedge clk);
      if (c == 2) chk("pair10", 32'({load_add, add_sub}), 32'b11);
      if (c == 4) chk("pair01", 32'({load_add, add_sub}), 32'b10);
      if (c == 6) chk("pair11", 32'({load_add, add_sub}), 32'b00);
      if (c == 3 || c == 5 || c == 7) chk("shift_after_eval", 32'(shift_HQ_LQ_Q_1), 32'h1);
      next_cycle();
      start = 1'b0;
    end
    {q0_r, q1_r} = 2'b00;

    // Starts while busy are ignored; a held start re-triggers right after DONE.
    dn = 0;
    for (int c = 0; c <= 12; c++) begin
      start = (c == 0 || c == 4 || c == 8 || c >= 11);
      @(negedge clk);
      if (c >= 1 && c <= 11 && done) dn++;
      if (c == 10) chk("done_c10", 32'(done), 32'h1);
      if (c == 11) chk("idle_c11", 32'(busy), 32'h0);
      if (c == 12) chk("reload_c12", 32'(load_A), 32'h1);
      next_cycle();
    end
    chk("single_done", 32'(dn), 32'h1);
    start = 1'b0;
    repeat (LAST + 2) next_cycle();

    // Abort during the third SHIFT.
    dn = 0;
    for (int c = 0; c <= 12; c++) begin
      start = (c == 0);
      rst   = (c == 7);
      @(negedge clk);
      if (c == 7) chk("third_shift", 32'(shift_HQ_LQ_Q_1), 32'h1);
      if (c == 8) chk("abort_idle", 32'(got_v), 32'h0);
      if (c >= 8 && done) dn++;
      next_cycle();
    end
    rst = 1'b0;
    chk("no_done_after_abort", 32'(dn), 32'h0);
    dn = -1;
    for (int c = 0; c <= LAST + 3; c++) begin
      start = (c == 0);
      @(negedge clk);
      if (done && dn < 0) dn = c;
      next_cycle();
    end
    chk("latency_after_abort", 32'(dn), 32'(LAST));

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(49) == 0);
      start = ($urandom_range(2) == 0);
      q0_r  = 1'($urandom);
      q1_r  = 1'($urandom);
      next_cycle();
    end
    rst = 1'b1; start = 1'b0;
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Closed loop with the datapath model.
    cl_mode = 1'b1;
    mul_check(4'd3, 4'b1011, 8'hF1);
    mul_check(4'b1000, 4'b1000, 8'h40);
    for (int i = 0; i < 16; i++) begin
      sa   = N'($urandom);
      sb   = N'($urandom);
      prod = int'(sa) * int'(sb);
      mul_check(sa, sb, prod[2*N-1:0]);
    end
    cl_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
